// File: rtl/complex_mult_pipe.sv
// Four-stage pipelined complex multiplier: y = a*b or a*conj(b) per sample, with
// valid/ready flow control, optional round-half-up scaling and output saturation.
module complex_mult_pipe #(
  parameter int unsigned DINA_WIDTH = 8,
  parameter int unsigned DINB_WIDTH = 8,
  parameter int unsigned DOUT_WIDTH = 17,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned ROUND      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  conj,
  input  logic [DINA_WIDTH-1:0] a_i,
  input  logic [DINA_WIDTH-1:0] a_q,
  input  logic [DINB_WIDTH-1:0] b_i,
  input  logic [DINB_WIDTH-1:0] b_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] y_i,
  output logic [DOUT_WIDTH-1:0] y_q,
  output logic                  sat
);

  localparam int unsigned ProdWidth = DINA_WIDTH + DINB_WIDTH;
  localparam int unsigned FullWidth = DINA_WIDTH + DINB_WIDTH + 1;
  localparam int unsigned TopWidth  = FullWidth - DOUT_WIDTH + 2;
  localparam int unsigned RndShift  = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam bit          RndEn     = (ROUND != 0) && (SHIFT > 0);

  logic adv;

  logic                         v1_q, v2_q, v3_q;
  logic                         conj1_q, conj2_q;
  logic signed [DINA_WIDTH-1:0] ai1_q, aq1_q;
  logic signed [DINB_WIDTH-1:0] bi1_q, bq1_q;
  logic signed [ProdWidth-1:0]  pii_q, pqq_q, piq_q, pqi_q;
  logic signed [FullWidth-1:0]  full_i_d, full_q_d, full_i_q, full_q_q;
  logic [DOUT_WIDTH:0]          sc_i, sc_q;

  // Global enable: the whole pipe freezes while the output is held.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      conj1_q <= 1'b0;
      ai1_q   <= '0;
      aq1_q   <= '0;
      bi1_q   <= '0;
      bq1_q   <= '0;
    end else if (adv) begin
      v1_q    <= in_valid;
      conj1_q <= conj;
      ai1_q   <= a_i;
      aq1_q   <= a_q;
      bi1_q   <= b_i;
      bq1_q   <= b_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      conj2_q <= 1'b0;
      pii_q   <= '0;
      pqq_q   <= '0;
      piq_q   <= '0;
      pqi_q   <= '0;
    end else if (adv) begin
      v2_q    <= v1_q;
      conj2_q <= conj1_q;
      pii_q   <= ProdWidth'(ai1_q) * ProdWidth'(bi1_q);
      pqq_q   <= ProdWidth'(aq1_q) * ProdWidth'(bq1_q);
      piq_q   <= ProdWidth'(ai1_q) * ProdWidth'(bq1_q);
      pqi_q   <= ProdWidth'(aq1_q) * ProdWidth'(bi1_q);
    end
  end

  // The conjugate is folded into the add/subtract choice so no operand is ever negated.
  always_comb begin
    full_i_d = FullWidth'(pii_q) - FullWidth'(pqq_q);
    full_q_d = FullWidth'(piq_q) + FullWidth'(pqi_q);
    if (conj2_q) begin
      full_i_d = FullWidth'(pii_q) + FullWidth'(pqq_q);
      full_q_d = FullWidth'(pqi_q) - FullWidth'(piq_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_q     <= 1'b0;
      full_i_q <= '0;
      full_q_q <= '0;
    end else if (adv) begin
      v3_q     <= v2_q;
      full_i_q <= full_i_d;
      full_q_q <= full_q_d;
    end
  end

  // Returns {clipped, value}; one guard bit keeps the rounding add from wrapping.
  function automatic logic [DOUT_WIDTH:0] scale_sat(input logic signed [FullWidth-1:0] x);
    logic signed [FullWidth:0] ext;
    logic signed [FullWidth:0] r;
    logic [TopWidth-1:0]       top;
    ext = {x[FullWidth-1], x};
    if (RndEn) ext = ext + ((FullWidth + 1)'(1) << RndShift);
    r   = ext >>> SHIFT;
    top = r[FullWidth:DOUT_WIDTH-1];
    if ((&top) || (~|top)) begin
      scale_sat = {1'b0, r[DOUT_WIDTH-1:0]};
    end else if (r[FullWidth]) begin
      scale_sat = {2'b11, {(DOUT_WIDTH - 1){1'b0}}};
    end else begin
      scale_sat = {2'b10, {(DOUT_WIDTH - 1){1'b1}}};
    end
  endfunction

  always_comb begin
    sc_i = scale_sat(full_i_q);
    sc_q = scale_sat(full_q_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y_i       <= '0;
      y_q       <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      out_valid <= v3_q;
      y_i       <= sc_i[DOUT_WIDTH-1:0];
      y_q       <= sc_q[DOUT_WIDTH-1:0];
      sat       <= sc_i[DOUT_WIDTH] | sc_q[DOUT_WIDTH];
    end
  end

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Scoreboard bench: five parameterisations share one input stream and one out_ready;
// expected results come from an arithmetic reference model.
module tb_complex_mult_pipe;

  localparam int NCfg = 5;
  localparam int CfgShift[NCfg] = '{0, 8, 8, 1, 1};
  localparam int CfgRound[NCfg] = '{1, 1, 0, 1, 0};
  localparam int CfgDout[NCfg]  = '{17, 8, 8, 16, 16};

  typedef struct {
    int               acc;
    logic [4:0][31:0] ei;
    logic [4:0][31:0] eq;
    logic [4:0]       es;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       conj = 1'b0;
  logic [7:0] a_i = '0, a_q = '0, b_i = '0, b_q = '0;
  logic       out_ready = 1'b1;

  logic        ir[NCfg];
  logic        ov[NCfg];
  logic        sat_s[NCfg];
  int          yi_s[NCfg], yq_s[NCfg];
  logic [16:0] yi0, yq0;
  logic [7:0]  yi1, yq1, yi2, yq2;
  logic [15:0] yi3, yq3, yi4, yq4;

  int   n_checks = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_stall = -100;
  bit   rand_ready = 1'b0;
  bit   hold = 1'b0;
  int   pyi[NCfg], pyq[NCfg];
  logic psat[NCfg];
  exp_t sb[$];
  exp_t me;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  complex_mult_pipe #(.DINA_WIDTH(8), .DINB_WIDTH(8), .DOUT_WIDTH(17), .SHIFT(0), .ROUND(1)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .conj(conj),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .out_valid(ov[0]), .out_ready(out_ready),
    .y_i(yi0), .y_q(yq0), .sat(sat_s[0]));
  complex_mult_pipe #(.DINA_WIDTH(8), .DINB_WIDTH(8), .DOUT_WIDTH(8), .SHIFT(8), .ROUND(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .conj(conj),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .out_valid(ov[1]), .out_ready(out_ready),
    .y_i(yi1), .y_q(yq1), .sat(sat_s[1]));
  complex_mult_pipe #(.DINA_WIDTH(8), .DINB_WIDTH(8), .DOUT_WIDTH(8), .SHIFT(8), .ROUND(0)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .conj(conj),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .out_valid(ov[2]), .out_ready(out_ready),
    .y_i(yi2), .y_q(yq2), .sat(sat_s[2]));
  complex_mult_pipe #(.DINA_WIDTH(8), .DINB_WIDTH(8), .DOUT_WIDTH(16), .SHIFT(1), .ROUND(1)) d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .conj(conj),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .out_valid(ov[3]), .out_ready(out_ready),
    .y_i(yi3), .y_q(yq3), .sat(sat_s[3]));
  complex_mult_pipe #(.DINA_WIDTH(8), .DINB_WIDTH(8), .DOUT_WIDTH(16), .SHIFT(1), .ROUND(0)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[4]), .conj(conj),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q), .out_valid(ov[4]), .out_ready(out_ready),
    .y_i(yi4), .y_q(yq4), .sat(sat_s[4]));

  assign yi_s[0] = int'($signed(yi0));
  assign yq_s[0] = int'($signed(yq0));
  assign yi_s[1] = int'($signed(yi1));
  assign yq_s[1] = int'($signed(yq1));
  assign yi_s[2] = int'($signed(yi2));
  assign yq_s[2] = int'($signed(yq2));
  assign yi_s[3] = int'($signed(yi3));
  assign yq_s[3] = int'($signed(yq3));
  assign yi_s[4] = int'($signed(yi4));
  assign yq_s[4] = int'($signed(yq4));

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact complex product, then floor or round-half-up division by 2^sh, then clamp.
  function automatic void model(input int ai, aq, bi, bq, input bit cj, input int k,
                                output int yi, output int yq, output bit s);
    longint fi, fq, lim;
    bit ci, cq;
    fi  = cj ? longint'(ai * bi + aq * bq) : longint'(ai * bi - aq * bq);
    fq  = cj ? longint'(aq * bi - ai * bq) : longint'(ai * bq + aq * bi);
    if (CfgRound[k] != 0 && CfgShift[k] > 0) begin
      fi = fi + (longint'(1) <<< (CfgShift[k] - 1));
      fq = fq + (longint'(1) <<< (CfgShift[k] - 1));
    end
    fi  = fi >>> CfgShift[k];
    fq  = fq >>> CfgShift[k];
    lim = (longint'(1) <<< (CfgDout[k] - 1));
    ci  = (fi >= lim) || (fi < -lim);
    cq  = (fq >= lim) || (fq < -lim);
    if (fi >= lim) fi = lim - 1;
    if (fi < -lim) fi = -lim;
    if (fq >= lim) fq = lim - 1;
    if (fq < -lim) fq = -lim;
    yi = int'(fi);
    yq = int'(fq);
    s  = ci | cq;
  endfunction

  // Starts and ends just after a rising edge; holds the sample until it is accepted.
  task automatic send(input int ai, aq, bi, bq, input bit cj, input int oc = -1,
                      input int oi = 0, input int oq = 0, input bit os = 1'b0);
    exp_t e;
    int   yi, yq;
    bit   s;
    bit   done = 1'b0;
    a_i = 8'(ai); a_q = 8'(aq); b_i = 8'(bi); b_q = 8'(bq); conj = cj; in_valid = 1'b1;
    for (int t = 0; t < 500 && !done; t++) begin
      @(negedge clk);
      if (ir[0]) begin
        for (int k = 0; k < NCfg; k++) begin
          model(ai, aq, bi, bq, cj, k, yi, yq, s);
          e.ei[k] = yi; e.eq[k] = yq; e.es[k] = s;
        end
        if (oc >= 0) begin
          e.ei[oc] = oi; e.eq[oc] = oq; e.es[oc] = os;
        end
        e.acc = cyc;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check(1'b0, "send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check(ir[0] == (!ov[0] || out_ready), "in_ready", int'(ir[0]), int'(!ov[0] || out_ready));
      for (int k = 1; k < NCfg; k++)
        check(ov[k] == ov[0], $sformatf("out_valid_cfg%0d", k), int'(ov[k]), int'(ov[0]));
      if (hold) begin
        for (int k = 0; k < NCfg; k++) begin
          check(yi_s[k] == pyi[k], $sformatf("hold_y_i_cfg%0d", k), yi_s[k], pyi[k]);
          check(yq_s[k] == pyq[k], $sformatf("hold_y_q_cfg%0d", k), yq_s[k], pyq[k]);
          check(sat_s[k] == psat[k], $sformatf("hold_sat_cfg%0d", k), int'(sat_s[k]),
                int'(psat[k]));
        end
      end
      if (ov[0]) begin
        if (sb.size() == 0) begin
          check(1'b0, "spurious_out_valid", 1, 0);
        end else if (out_ready) begin
          me = sb.pop_front();
          for (int k = 0; k < NCfg; k++) begin
            check(yi_s[k] == int'(me.ei[k]), $sformatf("y_i_cfg%0d", k), yi_s[k], int'(me.ei[k]));
            check(yq_s[k] == int'(me.eq[k]), $sformatf("y_q_cfg%0d", k), yq_s[k], int'(me.eq[k]));
            check(sat_s[k] == me.es[k], $sformatf("sat_cfg%0d", k), int'(sat_s[k]),
                  int'(me.es[k]));
          end
          if (me.acc > last_stall) check(cyc - me.acc == 4, "latency", cyc - me.acc, 4);
        end
        if (!out_ready) last_stall = cyc;
      end
      hold = ov[0] && !out_ready;
      for (int k = 0; k < NCfg; k++) begin
        pyi[k] = yi_s[k]; pyq[k] = yq_s[k]; psat[k] = sat_s[k];
      end
    end else begin
      hold = 1'b0;
    end
  end

  initial begin
    int ai, aq, bi, bq;
    repeat (3) @(posedge clk);
    #1;
    check(ov[0] == 1'b0, "reset_out_valid", int'(ov[0]), 0);
    check(yi_s[0] == 0 && yq_s[0] == 0, "reset_y", yi_s[0] | yq_s[0], 0);
    check(ir[0] == 1'b1, "reset_in_ready", int'(ir[0]), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back-to-back with conj alternating.
    send(4, 5, 5, 4, 1'b0, 0, 0, 41, 1'b0);
    send(4, 5, 5, 4, 1'b1, 0, 40, 9, 1'b0);
    send(4, 5, 5, 4, 1'b0, 0, 0, 41, 1'b0);
    send(-128, -128, -128, -128, 1'b0, 0, 0, 32768, 1'b0);
    send(-128, -128, -128, -128, 1'b1, 0, 32768, 0, 1'b0);
    send(-128, -128, -128, -128, 1'b0, 1, 0, 127, 1'b1);
    send(-128, 0, 127, 0, 1'b0, 1, -63, 0, 1'b0);
    send(-128, 0, 127, 0, 1'b0, 2, -64, 0, 1'b0);
    send(3, 0, 1, 0, 1'b0, 3, 2, 0, 1'b0);
    send(3, 0, 1, 0, 1'b0, 4, 1, 0, 1'b0);
    send(-3, 0, 1, 0, 1'b0, 3, -1, 0, 1'b0);
    send(-3, 0, 1, 0, 1'b0, 4, -2, 0, 1'b0);
    idle(6);

    for (int i = 4; i < 16; i++)
      for (int j = 4; j < 16; j++)
        for (int c = 0; c < 2; c++) send(i, j, j, i, c[0]);
    idle(6);

    // Back-pressure: out_ready low for cycles 6..15 of a 20-sample stream.
    fork
      for (int k = 0; k < 20; k++) send(k, k + 1, 2 * k, -k, k[0]);
      begin
        repeat (6) begin
          @(posedge clk); #1;
        end
        out_ready = 1'b0;
        repeat (10) begin
          @(negedge clk);
          check(ir[0] == 1'b0, "in_ready_during_stall", int'(ir[0]), 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    idle(8);

    rand_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      ai = int'($urandom_range(0, 255)) - 128;
      aq = int'($urandom_range(0, 255)) - 128;
      bi = int'($urandom_range(0, 255)) - 128;
      bq = int'($urandom_range(0, 255)) - 128;
      send(ai, aq, bi, bq, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle(1);
    end
    idle(1);
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && sb.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    check(sb.size() == 0, "drain_before_reset", sb.size(), 0);

    // Mid-flight reset: the first sample is presenting, three more are in flight.
    send(4, 5, 5, 4, 1'b1);
    send(7, 2, 3, 9, 1'b0);
    send(1, 1, 1, 1, 1'b1);
    send(6, 6, 6, 6, 1'b0);
    in_valid = 1'b0;
    #1;
    check(ov[0] == 1'b1, "out_valid_before_reset", int'(ov[0]), 1);
    rst_n = 1'b0;
    #1;
    check(ov[0] == 1'b0, "async_reset_out_valid", int'(ov[0]), 0);
    check(yi_s[0] == 0, "async_reset_y_i", yi_s[0], 0);
    check(yq_s[0] == 0, "async_reset_y_q", yq_s[0], 0);
    check(ir[0] == 1'b1, "async_reset_in_ready", int'(ir[0]), 1);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    idle(8);
    send(9, -4, 2, 11, 1'b0, 0, 62, 91, 1'b0);
    idle(8);
    check(sb.size() == 0, "final_drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
